// File: rtl/exibe_diferenca.sv
// Four-digit multiplexed 7-segment display of a signed 0..15 difference.
// Captures magnitude/sign on valido and scans the digits (units, tens, sign,
// blank) with one digit lit every DIV clock cycles.
module exibe_diferenca #(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valido,
  input  logic [3:0] magnitude,
  input  logic       sinal,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       atualizado
);

  localparam int unsigned    CntW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(DIV - 1);
  localparam logic [6:0]     SegBlank = 7'b1111111;
  localparam logic [6:0]     SegMinus = 7'b0111111;

  typedef enum logic [1:0] {StEsc0, StEsc1, StEsc2, StEsc3} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      mag_q, mag_d;
  logic            sin_q, sin_d;
  logic            atual_q, atual_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            tick;
  logic            dezena;
  logic [3:0]      unidade;

  // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit.
  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SegBlank;
    endcase
    return p;
  endfunction

  // Scan-rate divider and operand capture.
  always_comb begin
    tick    = (cnt_q == CntMax);
    cnt_d   = tick ? '0 : cnt_q + CntW'(1);
    mag_d   = valido ? magnitude : mag_q;
    sin_d   = valido ? sinal : sin_q;
    atual_d = valido;
  end

  // Scan FSM next state: one digit step per tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        StEsc0:  state_d = StEsc1;
        StEsc1:  state_d = StEsc2;
        StEsc2:  state_d = StEsc3;
        default: state_d = StEsc0;
      endcase
    end
  end

  // Digit select and segment pattern for the current scan position.
  always_comb begin
    dezena  = (mag_q >= 4'd10);
    unidade = dezena ? mag_q - 4'd10 : mag_q;
    an_d    = 4'b0111;
    seg_d   = SegBlank;
    unique case (state_q)
      StEsc0: begin
        an_d  = 4'b1110;
        seg_d = font(unidade);
      end
      StEsc1: begin
        an_d  = 4'b1101;
        seg_d = dezena ? font(4'd1) : SegBlank;
      end
      StEsc2: begin
        an_d  = 4'b1011;
        seg_d = sin_q ? SegMinus : SegBlank;
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = SegBlank;
      end
    endcase
  end

  // All state; reset wins over a coincident capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEsc0;
      cnt_q   <= '0;
      mag_q   <= '0;
      sin_q   <= 1'b0;
      atual_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SegBlank;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      sin_q   <= sin_d;
      atual_q <= atual_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign atualizado = atual_q;

endmodule
